// File: rtl/cle_component_stats_if.sv
// Bus between the component-statistics block and its host/SRAM side:
// start handshake, label SRAM read port and result outputs.
interface cle_component_stats_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LBL_W  = 8,
    parameter int unsigned AREA_W = 11
);
    logic              start;
    logic [ADDR_W-1:0] sram_a;
    logic [LBL_W-1:0]  sram_q;
    logic              busy;
    logic              done;
    logic [LBL_W-1:0]  num_comp;
    logic [AREA_W-1:0] max_area;
    logic [LBL_W-1:0]  max_label;

    // Host / labeller / SRAM side
    modport master (
        output start, sram_q,
        input  sram_a, busy, done, num_comp, max_area, max_label
    );

    // Statistics block side
    modport slave (
        input  start, sram_q,
        output sram_a, busy, done, num_comp, max_area, max_label
    );
endinterface

// File: rtl/cle_component_stats.sv
// Connected-component statistics: scans the label image, histograms the
// labels, then sweeps the histogram for component count and largest area.
module cle_component_stats #(
    parameter int unsigned N_PIX  = 1024,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LBL_W  = 8,
    parameter int unsigned AREA_W = 11
) (
    input logic                   clk,
    input logic                   reset,
    cle_component_stats_if.slave  bus
);

    localparam int unsigned N_LBL = (1 << LBL_W) - 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SCAN  = 3'd1;
    localparam logic [2:0] DRAIN = 3'd2;
    localparam logic [2:0] SWEEP = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
    localparam logic [LBL_W-1:0]  LAST_LBL  = LBL_W'(N_LBL);

    logic [2:0]        state, state_next;
    logic [ADDR_W-1:0] sram_a;
    logic [LBL_W-1:0]  idx;
    logic [LBL_W-1:0]  num_comp;
    logic [LBL_W-1:0]  max_label;
    logic [AREA_W-1:0] max_area;
    logic              busy;
    logic              done;

    // Entry 0 exists only so any LBL_W-bit index is in range; label 0 never sets it.
    logic [N_LBL:0]    seen;
    logic [AREA_W-1:0] cnt [0:N_LBL];

    logic              capture;
    logic              pix_hit;
    logic [LBL_W-1:0]  q;

    assign q = bus.sram_q;
    // Read data lags the address by one cycle, so the first SCAN cycle has
    // nothing to take and DRAIN takes the last address's word.
    assign capture = ((state == SCAN) && (sram_a != '0)) || (state == DRAIN);
    assign pix_hit = capture && (q != '0);

    assign bus.sram_a    = sram_a;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.num_comp  = num_comp;
    assign bus.max_area  = max_area;
    assign bus.max_label = max_label;

    // Next-state sequencing of the scan / drain / sweep phases
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = SCAN;
            SCAN:    if (sram_a == LAST_ADDR) state_next = DRAIN;
            DRAIN:   state_next = SWEEP;
            SWEEP:   if (idx == LAST_LBL) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control state, address counter, seen bitmap and sweep accumulators
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sram_a    <= '0;
            idx       <= '0;
            num_comp  <= '0;
            max_area  <= '0;
            max_label <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            seen      <= '0;
        end else begin
            state <= state_next;
            // Flags are registered from the phase, so done lands one cycle after DONE
            busy  <= (state == SCAN) || (state == DRAIN) || (state == SWEEP);
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        seen      <= '0;
                        num_comp  <= '0;
                        max_area  <= '0;
                        max_label <= '0;
                        sram_a    <= '0;
                    end
                end
                SCAN: begin
                    if (sram_a != LAST_ADDR) sram_a <= sram_a + ADDR_W'(1);
                end
                DRAIN: begin
                    idx <= LBL_W'(1);
                end
                SWEEP: begin
                    if (seen[idx]) begin
                        num_comp <= num_comp + LBL_W'(1);
                        // Strict compare: on a tie the earlier (smaller) label wins
                        if (cnt[idx] > max_area) begin
                            max_area  <= cnt[idx];
                            max_label <= idx;
                        end
                    end
                    if (idx != LAST_LBL) idx <= idx + LBL_W'(1);
                end
                default: ;
            endcase
            if (pix_hit) seen[q] <= 1'b1;
        end
    end

    // Per-label pixel counters; a clear seen bit means the stored count is stale
    always_ff @(posedge clk) begin
        if (pix_hit) begin
            cnt[q] <= seen[q] ? cnt[q] + AREA_W'(1) : AREA_W'(1);
        end
    end

endmodule

// File: tb/tb_cle_component_stats.sv
// Self-checking bench for cle_component_stats: a synchronous SRAM model feeds
// label images; results are compared against a histogram reference model.
module tb_cle_component_stats;

    localparam int N_PIX   = 1024;
    localparam int LATENCY = 1281;

    logic clk = 1'b0;
    logic reset;

    cle_component_stats_if #(.ADDR_W(10), .LBL_W(8), .AREA_W(11)) bus ();

    cle_component_stats #(
        .N_PIX  (N_PIX),
        .ADDR_W (10),
        .LBL_W  (8),
        .AREA_W (11)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [N_PIX];

    // Synchronous-read label SRAM
    always @(posedge clk) bus.sram_q <= mem[bus.sram_a];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // Reference: histogram the image, then pick count and first-largest label
    task automatic ref_model(output int n, output int area, output int lbl);
        int hist [256];
        foreach (hist[i]) hist[i] = 0;
        for (int a = 0; a < N_PIX; a++) if (mem[a] != 0) hist[mem[a]]++;
        n = 0; area = 0; lbl = 0;
        for (int l = 1; l < 256; l++) begin
            if (hist[l] > 0) n++;
            if (hist[l] > area) begin
                area = hist[l];
                lbl  = l;
            end
        end
    endtask

    task automatic clear_mem(input int val);
        for (int a = 0; a < N_PIX; a++) mem[a] = 8'(val);
    endtask

    // Put n pixels of label lbl at distinct free addresses below 1023
    task automatic place(input int lbl, input int n);
        int a;
        for (int i = 0; i < n; i++) begin
            a = int'($urandom_range(N_PIX - 2, 0));
            while (mem[a] != 0) a = int'($urandom_range(N_PIX - 2, 0));
            mem[a] = 8'(lbl);
        end
    endtask

    task automatic gen_random(input int n_lbl, input int dens);
        int lbls [8];
        for (int i = 0; i < n_lbl; i++) lbls[i] = int'($urandom_range(255, 1));
        for (int a = 0; a < N_PIX; a++) begin
            if (int'($urandom_range(99, 0)) < dens)
                mem[a] = 8'(lbls[int'($urandom_range(n_lbl - 1, 0))]);
            else
                mem[a] = 8'd0;
        end
    endtask

    // Pulse start and wait (bounded) for done; optional second start and mid-scan reset
    task automatic run_scan(input int restart_at, input int reset_at,
                            output int lat, output bit got_done);
        bit saw;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = 0;
        got_done = 1'b0;
        while (lat < 2000 && !got_done) begin
            @(posedge clk);
            #1;
            lat++;
            bus.start = 1'b0;
            if (bus.done) got_done = 1'b1;
            if (lat == restart_at) bus.start = 1'b1;
            if (lat == 500) begin
                check_eq("scan_addr_500", int'(bus.sram_a), 500);
                check_eq("busy_mid_scan", int'(bus.busy), 1);
            end
            if (lat == reset_at) begin
                reset = 1'b0;
                #1;
                check_eq("rst_sram_a", int'(bus.sram_a), 0);
                check_eq("rst_busy", int'(bus.busy), 0);
                check_eq("rst_num_comp", int'(bus.num_comp), 0);
                check_eq("rst_max_area", int'(bus.max_area), 0);
                check_eq("rst_max_label", int'(bus.max_label), 0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                reset = 1'b1;
                saw = 1'b0;
                repeat (1400) begin
                    @(posedge clk);
                    #1;
                    if (bus.done) saw = 1'b1;
                end
                check_eq("no_done_after_reset", int'(saw), 0);
                return;
            end
        end
    endtask

    task automatic do_run(input string tag, input int restart_at);
        int n, area, lbl, lat;
        bit got_done;
        ref_model(n, area, lbl);
        run_scan(restart_at, -1, lat, got_done);
        check_eq({tag, "_done_seen"}, int'(got_done), 1);
        check_eq({tag, "_latency"}, lat, LATENCY);
        check_eq({tag, "_busy_at_done"}, int'(bus.busy), 0);
        check_eq({tag, "_num_comp"}, int'(bus.num_comp), n);
        check_eq({tag, "_max_area"}, int'(bus.max_area), area);
        check_eq({tag, "_max_label"}, int'(bus.max_label), lbl);
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse"}, int'(bus.done), 0);
        check_eq({tag, "_busy_after"}, int'(bus.busy), 0);
        check_eq({tag, "_hold_area"}, int'(bus.max_area), area);
    endtask

    initial begin
        int lat;
        bit got_done;
        reset = 1'b0;
        bus.start = 1'b0;
        clear_mem(0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_sram_a", int'(bus.sram_a), 0);
        check_eq("reset_busy", int'(bus.busy), 0);
        check_eq("reset_done", int'(bus.done), 0);
        check_eq("reset_num_comp", int'(bus.num_comp), 0);
        check_eq("reset_max_area", int'(bus.max_area), 0);
        check_eq("reset_max_label", int'(bus.max_label), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        clear_mem(0);
        do_run("all_zero", -1);

        clear_mem(1);
        do_run("all_one", -1);

        clear_mem(0);
        place(7, 10);
        place(3, 10);
        do_run("tie", -1);

        clear_mem(0);
        mem[N_PIX - 1] = 8'd255;
        place(2, 5);
        place(5, 40);
        place(9, 39);
        do_run("sparse", -1);

        do_run("restart_ignored", 300);

        clear_mem(0);
        place(4, 17);
        place(200, 23);
        run_scan(-1, 500, lat, got_done);
        do_run("after_reset", -1);

        // Back-to-back: a stale seen bit would leave label 7 at 1024+ pixels
        clear_mem(7);
        do_run("b2b_first", -1);
        clear_mem(0);
        place(7, 5);
        place(4, 6);
        do_run("b2b_second", -1);

        for (int r = 0; r < 4; r++) begin
            gen_random(1 + r * 2, int'($urandom_range(90, 10)));
            do_run($sformatf("random%0d", r), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cle_component_stats.md
Name: cle_component_stats

Overview:
- Post-labelling statistics stage that sits directly downstream of the connected-component labeller.
- After the labeller asserts finish, this block reads the 32x32 label image back from the shared label SRAM, one 8-bit label per pixel, where 0 means background.
- It reports the number of distinct components, the largest component's area, and that component's label to the result/host logic.

Parameters:
- N_PIX, 1024, pixels to scan (addresses 0..N_PIX-1)
- ADDR_W, 10, SRAM address width
- LBL_W, 8, label width; labels 1..2^LBL_W-1 are valid
- AREA_W, 11, area counter width (must hold N_PIX)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; driven by the labeller's finish
- sram_a  output  ADDR_W  label SRAM read address
- sram_q  input  LBL_W  label SRAM read data, valid one clock after sram_a
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse; results are valid from this cycle onward
- num_comp  output  LBL_W  count of distinct nonzero labels present
- max_area  output  AREA_W  pixel count of the largest component
- max_label  output  LBL_W  label of the largest component

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - sram_a, busy, done, num_comp, max_area, max_label all =0.
  - Valid bitmap cleared.
  - Applies mid-operation too: the scan is abandoned and no done is produced.
- Storage:
  - cnt[1..255], AREA_W bits each.
  - seen[1..255] valid bits; cnt is treated as 0 when seen=0, so no clear sweep is needed.
- IDLE:
  - start=1 → clear seen, num_comp, max_area and max_label; sram_a=0; go to SCAN.
  - start=0 → stay; results hold their last values.
- SCAN (N_PIX cycles):
  - sram_a increments by 1 each cycle, 0..N_PIX-1.
  - On the last address go to DRAIN; sram_a holds N_PIX-1.
  - From the second SCAN cycle, process data q from the previous address:
    - q!=0 → if seen[q], cnt[q]+=1; else seen[q]=1 and cnt[q]=1.
    - q=0 → ignored.
- DRAIN (1 cycle): process the final data word; idx=1; go to SWEEP.
- SWEEP (255 cycles, idx=1..255):
  - If seen[idx]: num_comp+=1.
  - If seen[idx] and cnt[idx] > max_area (strict): max_area=cnt[idx] and max_label=idx.
  - Ties therefore keep the smallest label.
  - After idx=255 go to DONE.
- DONE (1 cycle): done=1, busy=0; go to IDLE.
- Latency and flags:
  - start sampled at edge k → done high in the cycle following edge k+N_PIX+257, i.e. 1281 cycles for N_PIX=1024.
  - busy=1 in SCAN, DRAIN and SWEEP only.
- Block never writes SRAM; the labeller owns sram_wen and must have it deasserted (1).
- start while busy or in DONE: ignored, with no restart and no effect on results.
- Area arithmetic:
  - Cannot overflow (max N_PIX=1024 fits 11 bits).
  - num_comp saturates naturally at 255 (max distinct labels).
- All-background image: num_comp=0, max_area=0, max_label=0.

Test Plan:
1. All 1024 words =0, pulse start → done exactly 1281 cycles later; num_comp=0, max_area=0, max_label=0; busy low after done.
2. All 1024 words =1 → num_comp=1, max_area=1024, max_label=1.
3. Labels 3 (10 px) and 7 (10 px), rest 0 → num_comp=2, max_area=10, max_label=3 (tie keeps the lower label).
4. Sparse labels 2 (5 px), 5 (40 px), 9 (39 px) plus label 255 at address 1023 only → num_comp=4, max_area=40, max_label=5; confirms last-address DRAIN capture and idx=255.
5. Second start pulse mid-SCAN → ignored, results as for the single run. Drop reset to 0 at cycle 500 of a scan → all outputs 0 immediately, no done. New start after release → correct results.
6. Two back-to-back runs with different images → second run's results contain no stale counts from the first (seen bitmap cleared on start).
